// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode encoding, default datapath width and the
// captured result/flag bundle layout.
package alu_pkg;

  localparam int ALU_N = 32;

  typedef enum logic [3:0] {
    OP_AND = 4'd0,
    OP_OR  = 4'd1,
    OP_XOR = 4'd2,
    OP_NOT = 4'd3,
    OP_ADD = 4'd4,
    OP_SUB = 4'd5,
    OP_SLT = 4'd6
  } alu_op_e;

  typedef struct packed {
    logic z;
    logic n;
    logic c;
    logic v;
    logic err;
  } alu_flags_t;

  // Bundle at the default width; width-generic users build the same layout locally.
  typedef struct packed {
    logic [ALU_N-1:0] result;
    alu_flags_t       flags;
  } alu_bundle_t;

endpackage

// File: rtl/alu_flag_gen.sv
// Combinational result select and condition-flag generation for one ALU op.
module alu_flag_gen
  import alu_pkg::*;
#(
  parameter int N = ALU_N
) (
  input  logic [3:0]   op,
  input  logic [N-1:0] and_res,
  input  logic [N-1:0] or_res,
  input  logic [N-1:0] xor_res,
  input  logic [N-1:0] not_res,
  input  logic [N-1:0] add_res,
  input  logic [N-1:0] sub_res,
  input  logic         add_cout,
  input  logic         sub_bout,
  input  logic         a_msb,
  input  logic         b_msb,
  output logic [N-1:0] result,
  output alu_flags_t   flags
);

  logic v_add;
  logic v_sub;
  logic c_sel;
  logic v_sel;
  logic err;

  // Signed overflow: operands agree (add) / disagree (sub) in sign and the result flips it.
  assign v_add = (a_msb == b_msb) & (add_res[N-1] != a_msb);
  assign v_sub = (a_msb != b_msb) & (sub_res[N-1] != a_msb);

  always_comb begin
    result = '0;
    c_sel  = 1'b0;
    v_sel  = 1'b0;
    err    = 1'b0;
    case (op)
      OP_AND: result = and_res;
      OP_OR:  result = or_res;
      OP_XOR: result = xor_res;
      OP_NOT: result = not_res;
      OP_ADD: begin
        result = add_res;
        c_sel  = add_cout;
        v_sel  = v_add;
      end
      OP_SUB: begin
        result = sub_res;
        c_sel  = sub_bout;
        v_sel  = v_sub;
      end
      OP_SLT: result = {{(N-1){1'b0}}, sub_res[N-1] ^ v_sub};
      default: err = 1'b1;
    endcase
  end

  assign flags.z   = (result == '0);
  assign flags.n   = result[N-1];
  assign flags.c   = c_sel;
  assign flags.v   = v_sel;
  assign flags.err = err;

endmodule

// File: rtl/alu_result_stage.sv
// Registered ALU output stage: main register plus one skid entry behind a
// valid/ready interface, with a wrapping completed-operation counter.
module alu_result_stage
  import alu_pkg::*;
#(
  parameter int N     = ALU_N,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [N-1:0]     and_res,
  input  logic [N-1:0]     or_res,
  input  logic [N-1:0]     xor_res,
  input  logic [N-1:0]     not_res,
  input  logic [N-1:0]     add_res,
  input  logic [N-1:0]     sub_res,
  input  logic             add_cout,
  input  logic             sub_bout,
  input  logic             a_msb,
  input  logic             b_msb,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N-1:0]     result,
  output logic             flag_z,
  output logic             flag_n,
  output logic             flag_c,
  output logic             flag_v,
  output logic             flag_err,
  output logic [CNT_W-1:0] op_count
);

  typedef struct packed {
    logic [N-1:0] result;
    alu_flags_t   flags;
  } bundle_t;

  bundle_t          in_b;
  bundle_t          main_q;
  bundle_t          skid_q;
  logic             main_valid;
  logic             skid_valid;
  logic [CNT_W-1:0] cnt_q;
  logic             accept;
  logic             drain;

  alu_flag_gen #(.N(N)) u_flag_gen (
    .op       (op),
    .and_res  (and_res),
    .or_res   (or_res),
    .xor_res  (xor_res),
    .not_res  (not_res),
    .add_res  (add_res),
    .sub_res  (sub_res),
    .add_cout (add_cout),
    .sub_bout (sub_bout),
    .a_msb    (a_msb),
    .b_msb    (b_msb),
    .result   (in_b.result),
    .flags    (in_b.flags)
  );

  // Handshake: a transfer happens on any rising edge where valid & ready are both
  // high; a valid producer holds its bundle stable until that edge. in_ready is
  // purely registered (skid empty), so it never depends on out_ready.
  assign in_ready = ~skid_valid;
  assign accept   = in_valid & in_ready;
  assign drain    = main_valid & out_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      main_q     <= '0;
      skid_q     <= '0;
      cnt_q      <= '0;
    end else if (drain) begin
      cnt_q <= cnt_q + CNT_W'(1);
      // A full skid implies in_ready was low, so no accept can coincide here.
      if (skid_valid) begin
        main_q     <= skid_q;
        skid_valid <= 1'b0;
      end else if (accept) begin
        main_q <= in_b;
      end else begin
        main_valid <= 1'b0;
      end
    end else if (accept) begin
      if (!main_valid) begin
        main_q     <= in_b;
        main_valid <= 1'b1;
      end else begin
        skid_q     <= in_b;
        skid_valid <= 1'b1;
      end
    end
  end

  assign out_valid = main_valid;
  assign result    = main_q.result;
  assign flag_z    = main_q.flags.z;
  assign flag_n    = main_q.flags.n;
  assign flag_c    = main_q.flags.c;
  assign flag_v    = main_q.flags.v;
  assign flag_err  = main_q.flags.err;
  assign op_count  = cnt_q;

endmodule

// File: tb/tb_alu_result_stage.sv
// Self-checking bench for alu_result_stage: operand-level reference model with a
// 2-deep FIFO view of the stage, random traffic, and directed corner sequences.
module tb_alu_result_stage;

  localparam int N  = 32;
  localparam int BW = N + 5;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [3:0]   op_r = 4'd0;
  logic [N-1:0] a_r = '0;
  logic [N-1:0] b_r = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [N-1:0] result;
  logic         flag_z, flag_n, flag_c, flag_v, flag_err;
  logic [15:0]  op_count;

  // Function-unit emulation feeding the stage.
  logic [N:0]   add_full;
  assign add_full = {1'b0, a_r} + {1'b0, b_r};

  alu_result_stage #(.N(N), .CNT_W(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op_r),
    .and_res   (a_r & b_r),
    .or_res    (a_r | b_r),
    .xor_res   (a_r ^ b_r),
    .not_res   (~a_r),
    .add_res   (add_full[N-1:0]),
    .sub_res   (a_r - b_r),
    .add_cout  (add_full[N]),
    .sub_bout  (a_r < b_r),
    .a_msb     (a_r[N-1]),
    .b_msb     (b_r[N-1]),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .flag_z    (flag_z),
    .flag_n    (flag_n),
    .flag_c    (flag_c),
    .flag_v    (flag_v),
    .flag_err  (flag_err),
    .op_count  (op_count)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [BW-1:0] exp_q[$];
  int exp_cnt = 0;
  bit model_live = 1'b0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
    end
  endtask

  // Expected bundle from operand values and opcode, using full-precision arithmetic.
  function automatic logic [BW-1:0] ref_bundle(input logic [3:0] o, input logic [N-1:0] a,
                                               input logic [N-1:0] b);
    longint sa, sb, s;
    logic [N-1:0] r;
    logic [N:0] t;
    logic c, v, e;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    r = '0; c = 1'b0; v = 1'b0; e = 1'b0;
    case (o)
      4'd0: r = a & b;
      4'd1: r = a | b;
      4'd2: r = a ^ b;
      4'd3: r = ~a;
      4'd4: begin
        t = {1'b0, a} + {1'b0, b};
        r = t[N-1:0];
        c = t[N];
        s = sa + sb;
        v = (s != longint'($signed(r)));
      end
      4'd5: begin
        r = a - b;
        c = (a < b);
        s = sa - sb;
        v = (s != longint'($signed(r)));
      end
      4'd6: r = (sa < sb) ? 32'd1 : 32'd0;
      default: e = 1'b1;
    endcase
    return {r, (r == '0), r[N-1], c, v, e};
  endfunction

  // Model: the stage behaves as a 2-deep FIFO; ready means fewer than 2 held.
  always @(posedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      exp_cnt = 0;
      model_live = 1'b1;
    end else begin
      bit drn, acc;
      drn = (exp_q.size() > 0) && out_ready;
      acc = in_valid && (exp_q.size() < 2);
      if (drn) begin
        void'(exp_q.pop_front());
        exp_cnt++;
      end
      if (acc) exp_q.push_back(ref_bundle(op_r, a_r, b_r));
    end
  end

  logic [BW-1:0] got_b;
  assign got_b = {result, flag_z, flag_n, flag_c, flag_v, flag_err};

  always @(negedge clk) begin
    if (model_live) begin
      chk("out_valid", 64'(out_valid), 64'(exp_q.size() > 0));
      chk("in_ready", 64'(in_ready), 64'(exp_q.size() < 2));
      chk("op_count", 64'(op_count), 64'(exp_cnt % 65536));
      if (exp_q.size() > 0) chk("bundle", 64'(got_b), 64'(exp_q[0]));
    end
  end

  // ---------------- driver tasks ----------------
  function automatic logic [N-1:0] rand_word();
    case ($urandom_range(0, 5))
      0: return 32'h0000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  function automatic logic [3:0] rand_op();
    int k;
    k = $urandom_range(0, 9);
    if (k > 6) return 4'($urandom_range(7, 15));
    return 4'(k);
  endfunction

  task automatic set_op(input logic [3:0] o, input logic [N-1:0] a, input logic [N-1:0] b);
    op_r = o;
    a_r  = a;
    b_r  = b;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_op_count", 64'(op_count), 64'd0);
    chk("rst_bundle", 64'(got_b), 64'd0);
    rst_n = 1'b1;
  endtask

  // Single op through an empty stage with downstream always ready.
  task automatic one_op(input string name, input logic [3:0] o, input logic [N-1:0] a,
                        input logic [N-1:0] b, input logic [BW-1:0] exp_b);
    @(negedge clk);
    set_op(o, a, b);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    chk({name, "_valid"}, 64'(out_valid), 64'd1);
    chk(name, 64'(got_b), 64'(exp_b));
    @(negedge clk);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    bit rdy_prev;
    do_reset();

    // Directed ops (hand-computed expectations).
    one_op("add_zero", 4'd4, 32'h8000_0000, 32'h8000_0000, {32'h0, 5'b10110});
    chk("add_count", 64'(op_count), 64'd1);
    one_op("not_ones", 4'd3, 32'h0, 32'h0, {32'hFFFF_FFFF, 5'b01000});
    one_op("slt_neg", 4'd6, 32'hFFFF_FFFF, 32'h1, {32'h1, 5'b00000});
    one_op("illegal9", 4'd9, 32'h1234_5678, 32'h1, {32'h0, 5'b10001});
    chk("directed_count", 64'(op_count), 64'd4);

    // Stall: three back-to-back ops, downstream blocked for two cycles.
    do_reset();
    @(negedge clk);
    out_ready = 1'b0;
    set_op(4'd4, 32'd1, 32'd2);
    in_valid = 1'b1;
    @(negedge clk);
    chk("stall_rdy1", 64'(in_ready), 64'd1);
    set_op(4'd2, 32'hF0F0_0000, 32'h0FF0_0000);
    @(negedge clk);
    chk("stall_rdy_low", 64'(in_ready), 64'd0);
    set_op(4'd5, 32'd5, 32'd7);
    @(negedge clk);
    chk("stall_hold", 64'(result), 64'd3);
    chk("stall_rdy_low2", 64'(in_ready), 64'd0);
    out_ready = 1'b1;
    @(negedge clk);
    chk("stall_second", 64'(result), 64'hFF00_0000);
    chk("stall_rdy_back", 64'(in_ready), 64'd1);
    @(negedge clk);
    in_valid = 1'b0;
    chk("stall_third", 64'(result), 64'hFFFF_FFFE);
    @(negedge clk);
    chk("stall_empty", 64'(out_valid), 64'd0);
    chk("stall_count", 64'(op_count), 64'd3);

    // Reset with main and skid both full, inputs still asserted.
    @(negedge clk);
    out_ready = 1'b0;
    set_op(4'd1, 32'hAAAA_0000, 32'h0000_5555);
    in_valid = 1'b1;
    repeat (3) @(negedge clk);
    chk("full_before_rst", 64'(in_ready), 64'd0);
    do_reset();
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("no_stale", 64'(out_valid), 64'd0);
    one_op("after_rst", 4'd1, 32'h1234, 32'h10, {32'h1234, 5'b00000});
    chk("after_rst_count", 64'(op_count), 64'd1);

    // Random traffic with random back-pressure.
    rdy_prev = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (in_valid && rdy_prev) in_valid = 1'b0;
      if (!in_valid && ($urandom_range(0, 9) < 7)) begin
        set_op(rand_op(), rand_word(), rand_word());
        in_valid = 1'b1;
      end
      out_ready = ($urandom_range(0, 9) < 6);
      rdy_prev = in_ready;
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (4) @(negedge clk);

    // Counter wrap: 65536 full-rate transfers from zero return op_count to 0.
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 65536; i++) begin
      @(negedge clk);
      set_op(rand_op(), rand_word(), rand_word());
      in_valid = 1'b1;
    end
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("wrap_count", 64'(op_count), 64'd0);
    chk("wrap_empty", 64'(out_valid), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1500000;
    $display("FAIL watchdog timeout t=%0t", $time);
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
